// File: rtl/distance_filter.sv
// Moving-average filter for the ultrasonic distance word,
// with stale-data timeout and a hysteretic proximity flag.
module distance_filter #(
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE   = 4,
  parameter int TIMEOUT  = 1_000_000,
  parameter int NEAR_ON  = 12,
  parameter int NEAR_OFF = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  input  logic [7:0] distance_in,
  output logic [7:0] distance_out,
  output logic       out_valid,
  output logic       stale,
  output logic       near
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = 8 + AVG_LOG2;
  localparam int CW = $clog2(SETTLE) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE_S = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] UPDATE  = 2'd3;

  logic [1:0]          state;
  logic                sync1, sync2, sync2_d;
  logic                fall;
  logic [CW-1:0]       settle_cnt;
  logic [7:0]          mem [N];
  logic [AVG_LOG2-1:0] wptr;
  logic [SW-1:0]       sum;
  logic                primed;
  logic [TW-1:0]       stale_cnt;
  logic                near_q;
  logic [7:0]          avg;
  logic [SW-1:0]       sample_ext;

  assign fall       = ~sync2 & sync2_d;
  assign avg        = sum[SW-1:AVG_LOG2];
  assign sample_ext = {{AVG_LOG2{1'b0}}, distance_in};
  assign stale      = (stale_cnt == TW'(TIMEOUT));
  assign near       = near_q & ~stale;

  // Bring the asynchronous pwm line into the clock domain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= pwm_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  // Sequencer: wait after a falling edge, capture, then publish.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fall) begin
            state      <= SETTLE_S;
            settle_cnt <= '0;
          end
        end
        SETTLE_S: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == CW'(SETTLE - 1)) state <= CAPTURE;
        end
        CAPTURE: state <= UPDATE;
        default: state <= IDLE;
      endcase
    end
  end

  // Circular sample buffer and running sum; first sample primes all taps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr   <= '0;
      sum    <= '0;
      primed <= 1'b0;
    end else if (state == CAPTURE) begin
      wptr <= wptr + 1'b1;
      if (!primed) begin
        for (int i = 0; i < N; i++) mem[i] <= distance_in;
        sum    <= sample_ext << AVG_LOG2;
        primed <= 1'b1;
      end else begin
        mem[wptr] <= distance_in;
        sum       <= sum + sample_ext - {{AVG_LOG2{1'b0}}, mem[wptr]};
      end
    end
  end

  // Publish the average and refresh the proximity flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      distance_out <= '0;
      out_valid    <= 1'b0;
      near_q       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == UPDATE) begin
        distance_out <= avg;
        out_valid    <= 1'b1;
        if (avg <= 8'(NEAR_ON))     near_q <= 1'b1;
        else if (avg > 8'(NEAR_OFF)) near_q <= 1'b0;
      end else if (stale) begin
        near_q <= 1'b0;
      end
    end
  end

  // Age of the last published sample, saturating at the timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stale_cnt <= TW'(TIMEOUT);
    end else if (state == UPDATE) begin
      stale_cnt <= '0;
    end else if (!stale) begin
      stale_cnt <= stale_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_distance_filter.sv
// Directed bench for distance_filter: priming, latency,
// averaging, hysteresis, stale timeout and mid-sequence reset.
module tb_distance_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic [7:0] distance_in;
  logic [7:0] distance_out;
  logic       out_valid;
  logic       stale;
  logic       near;

  int n_chk  = 0;
  int n_pass = 0;

  distance_filter #(
    .AVG_LOG2(2),
    .SETTLE  (4),
    .TIMEOUT (1000),
    .NEAR_ON (12),
    .NEAR_OFF(18)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .distance_in (distance_in),
    .distance_out(distance_out),
    .out_valid   (out_valid),
    .stale       (stale),
    .near        (near)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a high-low pulse; return edges from edge k until out_valid
  // is observed (9 means just after edge k+8), or -1 on timeout.
  task automatic pulse(input logic [7:0] d, output int lat);
    distance_in = d;
    pwm_in = 1'b1;
    tick(4);
    pwm_in = 1'b0;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) chk("ov_timeout", 0, 1);
    tick(1);
    chk("ov_width", int'(out_valid), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(10);
    reset = 1'b1;
    tick(1);
  endtask

  int lat;
  int seen;
  logic [7:0] exp_avg [4] = '{8'd32, 8'd26, 8'd26, 8'd22};
  logic [7:0] in_avg  [4] = '{8'd8, 8'd16, 8'd40, 8'd24};

  initial begin
    reset = 1'b0;
    pwm_in = 1'b0;
    distance_in = 8'd0;
    @(posedge clk);
    #1;

    // Reset: pwm wiggles while held in reset, then idles low.
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      pwm_in = i[1];
      tick(1);
      if (out_valid) seen++;
    end
    chk("rst_dist", int'(distance_out), 0);
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_near", int'(near), 0);
    chk("rst_stale", int'(stale), 1);
    pwm_in = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (out_valid) seen++;
    end
    pwm_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (out_valid) seen++;
    end
    chk("idle_ov", seen, 0);

    // Prime and latency.
    pulse(8'd40, lat);
    chk("latency", lat, 9);
    chk("prime_dist", int'(distance_out), 40);
    chk("prime_stale", int'(stale), 0);

    // Moving average across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      pulse(in_avg[i], lat);
      chk($sformatf("avg%0d", i), int'(distance_out), int'(exp_avg[i]));
    end

    // Hysteresis.
    do_reset();
    pulse(8'd10, lat);
    chk("hy_prime", int'(near), 1);
    for (int i = 0; i < 4; i++) pulse(8'd15, lat);
    chk("hy15_dist", int'(distance_out), 15);
    chk("hy15_near", int'(near), 1);
    for (int i = 0; i < 3; i++) pulse(8'd20, lat);
    chk("hy18_dist", int'(distance_out), 18);
    chk("hy18_near", int'(near), 1);
    pulse(8'd20, lat);
    chk("hy20_near", int'(near), 0);
    for (int i = 0; i < 4; i++) pulse(8'd12, lat);
    chk("hy12_dist", int'(distance_out), 12);
    chk("hy12_near", int'(near), 1);

    // Stale timeout: ~1000 clocks after the last update.
    tick(980);
    chk("pre_stale", int'(stale), 0);
    chk("pre_near", int'(near), 1);
    tick(30);
    chk("stale_on", int'(stale), 1);
    chk("stale_near", int'(near), 0);
    chk("stale_dist", int'(distance_out), 12);
    pulse(8'd12, lat);
    chk("stale_off", int'(stale), 0);
    chk("stale_near2", int'(near), 1);

    // Reset mid-settle aborts, next pulse re-primes.
    distance_in = 8'd50;
    pwm_in = 1'b1;
    tick(4);
    pwm_in = 1'b0;
    tick(4);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (out_valid) seen++;
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (out_valid) seen++;
    end
    chk("mid_ov", seen, 0);
    chk("mid_dist", int'(distance_out), 0);
    chk("mid_stale", int'(stale), 1);
    chk("mid_near", int'(near), 0);
    pulse(8'd30, lat);
    chk("reprime", int'(distance_out), 30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/distance_filter.md
# distance_filter

Smooths the 8-bit distance word produced by the ultrasonic `pwm_measure` stage. On each sensor pulse it captures one sample and keeps a 2^AVG_LOG2-tap moving average. It also reports a data-stale flag and a hysteretic "near" proximity flag. It sits directly downstream of `pwm_measure`, watches the same raw `pwm_in` line to know when a fresh measurement has landed, and feeds the control logic.

## Interface
- AVG_LOG2, 2: log2 of averaging depth N (N = 4 by default).
- SETTLE, 4: clocks to wait after a `pwm_in` falling edge before capturing `distance_in`. Lets `pwm_measure` finish its update. Must be ≥ 1.
- TIMEOUT, 1_000_000: clocks without a new sample before `stale` asserts (100 ms at 10 MHz).
- NEAR_ON, 12: `near` sets when the averaged distance is ≤ this value.
- NEAR_OFF, 18: `near` clears when the averaged distance is > this value. Must be > NEAR_ON.

Ports:
- clk  in  1  system clock, 10 MHz.
- reset  in  1  synchronous, active-low reset.
- pwm_in  in  1  raw sensor PWM, asynchronous to `clk`.
- distance_in  in  8  distance from `pwm_measure`.
- distance_out  out  8  moving-average distance.
- out_valid  out  1  one-cycle pulse when `distance_out` updates.
- stale  out  1  no sample captured in the last TIMEOUT clocks.
- near  out  1  hysteretic proximity flag.

## Operation
- `pwm_in` passes through a 2-flop synchronizer (sync1, sync2) plus a delay flop (sync2_d). `fall` = sync2 & ~sync2_d inverted, i.e. sync2 == 0 && sync2_d == 1.
- FSM states:
  - IDLE: on `fall`, go to SETTLE and clear the settle counter.
  - SETTLE: the counter increments each clock. When the counter equals SETTLE-1, go to CAPTURE.
  - CAPTURE: sample `distance_in` into the circular buffer at the write pointer and update `sum`. Go to UPDATE.
  - UPDATE: `distance_out <= sum >> AVG_LOG2` (floor), `out_valid <= 1`, update `near`. Go to IDLE.
- Falling edges seen outside IDLE are ignored. Rising edges have no effect.
- Buffer: N entries of 8 bits with a write pointer that wraps modulo N.
- `sum`: width 8+AVG_LOG2, so it cannot overflow. Update rule: `sum <= sum + new - buf[wptr]`.
- First capture after reset (a `primed` flag is clear): fill all N entries with the sample and set `sum = sample * N`, then set `primed`. The first output therefore equals the first sample.
- Stale counter:
  - Clears to 0 in UPDATE.
  - Otherwise increments each clock, saturating at TIMEOUT.
  - `stale = (counter == TIMEOUT)`.
- `near`:
  - In UPDATE, computed from the new average: set if avg ≤ NEAR_ON; clear if avg > NEAR_OFF; otherwise hold.
  - Forced to 0 on any cycle where `stale` is 1.

## Timing
- Reset values (reset == 0 at a clk edge):
  - `distance_out` = 0, `out_valid` = 0, `near` = 0, `stale` = 1 (stale counter preset to TIMEOUT).
  - FSM = IDLE, `primed` = 0, `wptr` = 0, `sum` = 0, sync flops = 0.
- Latency, with edge k the first clk edge at which `pwm_in` is sampled low after being high:
  - `fall` is seen at edge k+2, entering SETTLE.
  - CAPTURE is entered at edge k+2+SETTLE.
  - `sum` and the buffer update at edge k+3+SETTLE; `distance_in` is sampled at that edge.
  - `out_valid` is high for exactly the one cycle after edge k+4+SETTLE. `distance_out` and `near` change at that same edge.
- `stale` deasserts the cycle after the UPDATE edge. It reasserts TIMEOUT clocks later if no further sample arrives.
- Reset asserted mid-sequence (SETTLE, CAPTURE or UPDATE) aborts with no `out_valid`. The next sample re-primes the buffer.
- `distance_out` holds its value between updates, including while `stale` = 1.

## Test plan
- Reset: hold reset low for 10 clocks -> `distance_out` = 0, `out_valid` = 0, `near` = 0, `stale` = 1. `out_valid` stays 0 while `pwm_in` idles high and low.
- Prime and latency: SETTLE = 4, `distance_in` = 40, drive a `pwm_in` high-low pulse -> `out_valid` is one cycle wide, following edge k+8. `distance_out` = 40, `stale` drops.
- Average and wrap (AVG_LOG2 = 2): after the prime at 40, pulses with distances 8, 16, 40, 24 -> `distance_out` = 32, 26, 26, 22 respectively.
- Hysteresis (NEAR_ON = 12, NEAR_OFF = 18): prime at 10 -> `near` = 1. Prime path, then averages of 15 -> `near` stays 1. Average 20 -> `near` = 0. Average 12 -> `near` = 1.
- Stale (TIMEOUT = 1000 for simulation): after a valid sample, no falling edge for 1000 clocks -> `stale` = 1 and `near` = 0, `distance_out` unchanged. The next pulse clears `stale`.
- Reset mid-settle: assert reset 2 clocks into SETTLE -> no `out_valid`, outputs at reset values. The next pulse at distance 30 -> `distance_out` = 30 (re-primed).
